// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV32I load/store definitions:
//   - funct3 width/sign codes for loads (LB..LHU) and stores (SB..SW)
//   - lsu_state_t : load/store unit FSM states
//   - store_lanes_t / store_lanes() : byte-lane strobes and replicated data
//   - access_fault() : illegal-code and misalignment detection
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_lanes_t;

  // Strobes follow the byte offset; data is replicated across all lanes so
  // the memory can pick it up from whichever lane the strobe enables.
  function automatic store_lanes_t store_lanes(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
    store_lanes_t s;
    s.wstrb = 4'b1111;
    s.wdata = d;
    case (f3)
      F3_SB: begin
        s.wstrb = 4'b0001 << a;
        s.wdata = {4{d[7:0]}};
      end
      F3_SH: begin
        s.wstrb = 4'b0011 << {a[1], 1'b0};
        s.wdata = {2{d[15:0]}};
      end
      default: ;
    endcase
    return s;
  endfunction

  // A request flagged as both load and store is always a fault. Bit pattern
  // f3[1:0] gives the access size (00 byte, 01 half, 10 word).
  function automatic logic access_fault(input logic       ld,
                                        input logic       st,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
    logic bad_code;
    logic misaligned;
    if (ld) bad_code = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    else    bad_code = !(f3 inside {F3_SB, F3_SH, F3_SW});
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return (ld && st) || bad_code || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the execute-stage request, the memory bus and the writeback/status
// signals of the load/store unit.
//   modport slave  : the load/store unit itself
//   modport master : the surrounding pipeline + memory driving the unit
// -----------------------------------------------------------------------------
interface load_store_unit_if;

  // execute-stage request
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  // memory bus
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  // completion / writeback
  logic        done;
  logic        wb_en;
  logic [31:0] rdata;
  logic [4:0]  rd_out;
  logic        fault;
  logic        busy;

  modport slave (
    input  req_valid, is_load, is_store, funct3, addr, wdata, rd,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           done, wb_en, rdata, rd_out, fault, busy
  );

  modport master (
    output req_valid, is_load, is_store, funct3, addr, wdata, rd,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           done, wb_en, rdata, rd_out, fault, busy
  );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the byte/halfword lane addressed by
// addr_lo_i out of the bus word and sign- or zero-extends it.
//   rdata_i   : 32-bit word returned by the memory
//   addr_lo_i : byte offset within the word
//   funct3_i  : load width/sign code
//   result_o  : value written back to the register file
// -----------------------------------------------------------------------------
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'h0, byte_sel};
      F3_LHU:  result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit: accepts one memory operation at a time from the
// execute stage, issues it on a valid/ready memory bus, waits for read data
// on loads and signals completion with a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   lsu        : load_store_unit_if.slave (request, bus, writeback, status)
// Misaligned or illegal operations skip the bus and complete with fault=1.
// -----------------------------------------------------------------------------
module load_store_unit
  import rv_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);

  lsu_state_t   state_q, state_d;

  logic         accept;
  logic         req_fault;
  store_lanes_t st_lanes;

  logic         is_load_q;
  logic         fault_q;
  logic [2:0]   funct3_q;
  logic [1:0]   addr_lo_q;
  logic [4:0]   rd_pend_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  mem_wdata_q;
  logic [3:0]   mem_wstrb_q;
  logic         mem_we_q;
  logic [31:0]  rdata_q;
  logic [4:0]   rd_out_q;
  logic [31:0]  load_result;
  logic         rsp_take;

  // A request with both flags set is still taken, and then faults.
  assign accept    = lsu.req_valid && (state_q == ST_IDLE) &&
                     (lsu.is_load || lsu.is_store);
  assign req_fault = access_fault(lsu.is_load, lsu.is_store, lsu.funct3,
                                  lsu.addr[1:0]);
  assign st_lanes  = store_lanes(lsu.funct3, lsu.addr[1:0], lsu.wdata);
  assign rsp_take  = (state_q == ST_WAIT) && lsu.mem_rsp_valid;

  load_align u_align (
    .rdata_i   (lsu.mem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (load_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    lsu.req_ready     = 1'b0;
    lsu.mem_req_valid = 1'b0;
    lsu.done          = 1'b0;
    lsu.wb_en         = 1'b0;
    lsu.fault         = 1'b0;
    lsu.busy          = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        lsu.req_ready = 1'b1;
        lsu.busy      = 1'b0;
        if (accept) state_d = req_fault ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        lsu.mem_req_valid = 1'b1;
        if (lsu.mem_req_ready) state_d = is_load_q ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        if (lsu.mem_rsp_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        lsu.done  = 1'b1;
        lsu.fault = fault_q;
        lsu.wb_en = is_load_q && !fault_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture. Bus fields are formed at acceptance so they stay
  // stable for the whole REQ phase independent of the execute-stage inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q   <= 1'b0;
      fault_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      rd_pend_q   <= 5'd0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_we_q    <= 1'b0;
    end else if (accept) begin
      is_load_q <= lsu.is_load && !lsu.is_store;
      fault_q   <= req_fault;
      funct3_q  <= lsu.funct3;
      addr_lo_q <= lsu.addr[1:0];
      rd_pend_q <= lsu.rd;
      if (!req_fault) begin
        mem_addr_q <= {lsu.addr[31:2], 2'b00};
        if (lsu.is_load) begin
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= 4'h0;
          mem_wdata_q <= 32'h0;
        end else begin
          mem_we_q    <= 1'b1;
          mem_wstrb_q <= st_lanes.wstrb;
          mem_wdata_q <= st_lanes.wdata;
        end
      end
    end
  end

  // Writeback result changes only when a load response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= 32'h0;
      rd_out_q <= 5'd0;
    end else if (rsp_take) begin
      rdata_q  <= load_result;
      rd_out_q <= rd_pend_q;
    end
  end

  assign lsu.mem_addr  = mem_addr_q;
  assign lsu.mem_we    = mem_we_q;
  assign lsu.mem_wstrb = mem_wstrb_q;
  assign lsu.mem_wdata = mem_wdata_q;
  assign lsu.rdata     = rdata_q;
  assign lsu.rd_out    = rd_out_q;

endmodule
